// File: rtl/text_gpu.sv
// text_gpu: text-mode display controller with character/attribute VRAM, font ROM and bus register access
module text_gpu #(
   parameter int COLS   = 80,
   parameter int ROWS   = 30,
   parameter int CHAR_H = 16,
   parameter int X_W    = 10,
   parameter int Y_W    = 9
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [31:0]    W_ADDR,
   input  logic [31:0]    W_DAT_I,
   input  logic           W_STB,
   input  logic           W_WE,
   output logic [31:0]    W_DAT_O,
   output logic           W_ACK,
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  logic           de,
   input  logic           frame_tick,
   output logic           R,
   output logic           G,
   output logic           B
);
   localparam int N  = COLS * ROWS;
   localparam int AW = $clog2(N);
   localparam int SH = $clog2(CHAR_H);
   localparam logic [7:0] GLYPH_A [16] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66,
                                           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
   state_t state, state_n;

   logic [15:0]   vram [N];
   logic [1:0]    ctrl;
   logic [7:0]    cur_col, cur_row, scroll, blink_n, cnt;
   logic          phase;
   logic [15:0]   addr_q;
   logic          we_q;
   logic [31:0]   rdata, reg_rd, dat_d;
   logic          ack_d, wr, cell_ok;

   logic [8:0]    row_sum, row_c;
   logic [7:0]    col_c;
   logic [3:0]    grow_c;
   logic [AW-1:0] addr1;
   logic [3:0]    grow1, grow2;
   logic [2:0]    xl1, xl2, rgb_d;
   logic          vis1, vis2, cur1, cur2, ph1, ph2, pbit;
   logic [15:0]   cell2;
   logic [7:0]    glyph;
   logic          unused;

   assign unused  = ^{W_ADDR[31:16], W_DAT_I[31:16], cell2[15]};
   assign wr      = rst_n && state == S_IDLE && W_STB && W_WE;
   assign cell_ok = int'(addr_q[14:0]) < N;

   // bus FSM state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;

   // bus FSM next state: a strobe in IDLE always starts a three-cycle transaction
   always_comb
      state_n = state == S_IDLE ? (W_STB ? S_WAIT : S_IDLE) : state == S_WAIT ? S_ACK : S_IDLE;

   // bus FSM outputs, registered below so ACK lands on the third cycle after the strobe
   always_comb begin
      ack_d = state == S_ACK;
      dat_d = state == S_ACK ? rdata : 32'h0;
   end

   // registered acknowledge and read data
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         W_ACK   <= 1'b0;
         W_DAT_O <= 32'h0;
      end else begin
         W_ACK   <= ack_d;
         W_DAT_O <= dat_d;
      end

   // latch the request when a transaction starts
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         addr_q <= 16'h0;
         we_q   <= 1'b0;
      end else if (state == S_IDLE && W_STB) begin
         addr_q <= W_ADDR[15:0];
         we_q   <= W_WE;
      end

   // control register write port; committed on the edge that leaves IDLE
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ctrl    <= 2'b01;
         cur_col <= 8'h0;
         cur_row <= 8'h0;
         scroll  <= 8'h0;
         blink_n <= 8'd30;
      end else if (wr && W_ADDR[15])
         case (W_ADDR[1:0])
            2'd0: ctrl <= W_DAT_I[1:0];
            2'd1: {cur_row, cur_col} <= W_DAT_I[15:0];
            2'd2: scroll <= int'(W_DAT_I[7:0]) < ROWS ? W_DAT_I[7:0] : scroll;
            default: blink_n <= W_DAT_I[7:0] == 8'h0 ? 8'h1 : W_DAT_I[7:0];
         endcase

   // VRAM bus port write; out-of-range cells are dropped
   always_ff @(posedge clk)
      if (wr && !W_ADDR[15] && int'(W_ADDR[14:0]) < N) vram[AW'(W_ADDR[14:0])] <= W_DAT_I[15:0];

   // register read-back mux
   always_comb
      reg_rd = addr_q[1:0] == 2'd0 ? {30'h0, ctrl} :
               addr_q[1:0] == 2'd1 ? {16'h0, cur_row, cur_col} :
               addr_q[1:0] == 2'd2 ? {24'h0, scroll} : {24'h0, blink_n};

   // bus read data captured during WAIT; writes return zero
   always_ff @(posedge clk)
      if (state == S_WAIT)
         rdata <= we_q ? 32'h0 : addr_q[15] ? reg_rd : cell_ok ? {16'h0, vram[AW'(addr_q[14:0])]} : 32'h0;

   // blink frame counter and phase
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= 8'h0;
         phase <= 1'b0;
      end else if (frame_tick) begin
         cnt   <= cnt >= blink_n - 8'd1 ? 8'h0 : cnt + 8'd1;
         phase <= cnt >= blink_n - 8'd1 ? !phase : phase;
      end

   // S1 address computation with scroll wrap
   always_comb begin
      row_sum = 9'(y >> SH) + {1'b0, scroll};
      row_c   = row_sum >= 9'(ROWS) ? row_sum - 9'(ROWS) : row_sum;
      col_c   = 8'(x >> 3);
      grow_c  = 4'(y[SH-1:0]);
   end

   // S1 registers; all register-dependent decisions are taken here
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         addr1 <= '0;
         grow1 <= 4'h0;
         xl1   <= 3'h0;
         vis1  <= 1'b0;
         cur1  <= 1'b0;
         ph1   <= 1'b0;
      end else begin
         addr1 <= AW'(int'(row_c) * COLS + int'(col_c));
         grow1 <= grow_c;
         xl1   <= x[2:0];
         vis1  <= de && ctrl[0] && int'(col_c) < COLS && int'(row_c) < ROWS;
         cur1  <= ctrl[1] && phase && col_c == cur_col && row_c == {1'b0, cur_row} && int'(grow_c) >= CHAR_H - 2;
         ph1   <= phase;
      end

   // S2 VRAM display read
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cell2 <= 16'h0;
         grow2 <= 4'h0;
         xl2   <= 3'h0;
         vis2  <= 1'b0;
         cur2  <= 1'b0;
         ph2   <= 1'b0;
      end else begin
         cell2 <= vram[addr1];
         grow2 <= grow1;
         xl2   <= xl1;
         vis2  <= vis1;
         cur2  <= cur1;
         ph2   <= ph1;
      end

   // S3 font lookup, cursor inversion, blink and colour select
   always_comb begin
      glyph = cell2[7:0] == 8'h41 ? GLYPH_A[grow2] : cell2[7:0] == 8'hDB ? 8'hFF : 8'h00;
      pbit  = glyph[3'd7 - xl2] ^ cur2;
      rgb_d = !vis2 ? 3'b000 : (cell2[14] && !ph2) || !pbit ? cell2[13:11] : cell2[10:8];
   end

   // S3 output register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {R, G, B} <= 3'b000;
      else        {R, G, B} <= rgb_d;
endmodule
